// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared MemOp encodings, LSU state encoding and lane helpers
package lsu_pkg;

    localparam int BE_W   = 4;
    localparam int DATA_W = 32;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b011;
    localparam logic [2:0] MEMOP_HU = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_RESP,
        ST_ERR
    } lsu_state_e;

    function automatic logic illegal_op(input logic [2:0] op);
        return op > MEMOP_HU;
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        case (op)
            MEMOP_H, MEMOP_HU: return a[0];
            MEMOP_W:           return a != 2'b00;
            default:           return 1'b0;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] byte_enable(input logic [2:0] op, input logic [1:0] a);
        case (op)
            MEMOP_B, MEMOP_BU: return 4'b0001 << a;
            MEMOP_H, MEMOP_HU: return 4'b0011 << {a[1], 1'b0};
            MEMOP_W:           return 4'b1111;
            default:           return '0;
        endcase
    endfunction

    // Replicate into every lane so the byte enables alone pick the target bytes.
    function automatic logic [DATA_W-1:0] store_data(input logic [2:0] op, input logic [DATA_W-1:0] wd);
        case (op)
            MEMOP_B, MEMOP_BU: return {4{wd[7:0]}};
            MEMOP_H, MEMOP_HU: return {2{wd[15:0]}};
            default:           return wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects and sign/zero-extends the loaded byte/halfword/word
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        mem_op,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (mem_op)
            MEMOP_B:  result = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_BU: result = {24'h0, byte_sel};
            MEMOP_H:  result = {{16{half_sel[15]}}, half_sel};
            MEMOP_HU: result = {16'h0, half_sel};
            MEMOP_W:  result = rdata;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - RV32I load/store unit with req/gnt/rvalid data-memory port
// Optional request/response timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        mem_op,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [BE_W-1:0]   dmem_be,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata
);

    lsu_state_e        state, state_nxt;
    logic [2:0]        op_q;
    logic              wr_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] load_ext;
    logic              accept;
    logic              req_bad;

`ifdef LSU_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       to_hit;
    assign to_hit = (to_cnt == 8'(TIMEOUT_CYC - 1));
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    assign accept  = req_valid && (state == ST_IDLE);
    assign req_bad = illegal_op(mem_op) || misaligned(mem_op, addr[1:0]);

    lsu_load_align u_align (
        .rdata   (dmem_rdata),
        .addr_lo (addr_q[1:0]),
        .mem_op  (op_q),
        .result  (load_ext)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = req_bad ? ST_ERR : ST_REQ;
            end
            ST_REQ: begin
                if (dmem_gnt) state_nxt = wr_q ? ST_RESP : ST_WAIT_RSP;
`ifdef LSU_TIMEOUT_EN
                else if (to_hit) state_nxt = ST_ERR;
`endif
            end
            ST_WAIT_RSP: begin
                if (dmem_rvalid) state_nxt = ST_RESP;
`ifdef LSU_TIMEOUT_EN
                else if (to_hit) state_nxt = ST_ERR;
`endif
            end
            ST_RESP: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // rdata_q changes only on the edge that enters RESP/ERR, so it holds between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= mem_op;
                wr_q    <= mem_wr;
                addr_q  <= addr;
                wdata_q <= wdata;
                if (req_bad) rdata_q <= '0;
            end
            if (state == ST_REQ && dmem_gnt && wr_q) rdata_q <= '0;
            if (state == ST_WAIT_RSP && dmem_rvalid) rdata_q <= load_ext;
            if ((state == ST_REQ || state == ST_WAIT_RSP) && state_nxt == ST_ERR) rdata_q <= '0;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state_nxt != state) begin
            to_cnt <= '0;
        end else if (state == ST_REQ || state == ST_WAIT_RSP) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`endif

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign dmem_req   = (state == ST_REQ);
    assign dmem_we    = dmem_req && wr_q;
    assign dmem_be    = dmem_req ? byte_enable(op_q, addr_q[1:0]) : '0;
    assign dmem_addr  = dmem_req ? {addr_q[31:2], 2'b00} : '0;
    assign dmem_wdata = dmem_we ? store_data(op_q, wdata_q) : '0;
    assign resp_valid = (state == ST_RESP) || (state == ST_ERR);
    assign resp_err   = (state == ST_ERR);
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb/tb_lsu_mem_access.sv - self-checking bench for lsu_mem_access (vector table + random vs model)
module tb_lsu_mem_access;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, mem_wr;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata, resp_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic        resp_valid, resp_err, busy, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [3:0]  dmem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_access #(.TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mem_op(mem_op), .mem_wr(mem_wr), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        logic [2:0]  op;
        logic        wr;
        logic [31:0] addr, wdata, rdata;
        int          gdly, rdly;
        logic [3:0]  be;
        logic [31:0] dwdata, res;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        int          resp_cyc;
        logic [31:0] rdata;
        logic        err, saw_req, we, unstable, bad_busy, idle_ok;
        logic [3:0]  be;
        logic [31:0] addr, wd;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: access size from the op, lanes by shifting, extension by masking.
    function automatic vec_t model(input logic [2:0] op, input logic wr, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rdl);
        vec_t v;
        int sz, sh;
        logic [31:0] lane;
        v.op = op; v.wr = wr; v.addr = a; v.wdata = wd; v.rdata = rd; v.gdly = gd; v.rdly = rdl;
        case (op)
            3'd0, 3'd3: sz = 1;
            3'd1, 3'd4: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        sh = int'(a[1:0]);
        v.err = (sz == 0) || (sh % sz != 0);
        v.be = v.err ? 4'h0 : 4'(((1 << sz) - 1) << sh);
        v.dwdata = (sz == 1) ? {24'h0, wd[7:0]} * 32'h01010101 :
                   (sz == 2) ? {16'h0, wd[15:0]} * 32'h00010001 : wd;
        lane = rd >> (8 * sh);
        if (sz == 1) begin
            v.res = lane & 32'hFF;
            if (op == 3'd0 && v.res[7]) v.res = v.res | 32'hFFFFFF00;
        end else if (sz == 2) begin
            v.res = lane & 32'hFFFF;
            if (op == 3'd1 && v.res[15]) v.res = v.res | 32'hFFFF0000;
        end else begin
            v.res = rd;
        end
        if (v.err || wr) v.res = 32'h0;
        v.lat = v.err ? 1 : (wr ? 2 + gd : 3 + gd + rdl);
        return v;
    endfunction

    // Starts at a negedge with the DUT idle; plays memory; ends one cycle after resp_valid.
    task automatic run_op(input vec_t v, output res_t r);
        int cyc, waited, gcyc;
        cyc = 1; waited = 0; gcyc = -1;
        r.resp_cyc = -1; r.rdata = '0; r.err = 1'b0; r.saw_req = 1'b0; r.we = 1'b0;
        r.unstable = 1'b0; r.bad_busy = 1'b0; r.idle_ok = 1'b0; r.be = '0; r.addr = '0; r.wd = '0;
        req_valid = 1'b1; mem_op = v.op; mem_wr = v.wr; addr = v.addr; wdata = v.wdata;
        step();
        while (cyc < 300) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            req_valid = 1'($urandom); mem_op = 3'($urandom); mem_wr = 1'($urandom);
            addr = $urandom; wdata = $urandom;
            if (!busy || req_ready) r.bad_busy = 1'b1;
            if (resp_valid) begin
                r.resp_cyc = cyc; r.rdata = resp_rdata; r.err = resp_err;
                break;
            end
            if (dmem_req) begin
                if (!r.saw_req) begin
                    r.saw_req = 1'b1; r.be = dmem_be; r.addr = dmem_addr; r.we = dmem_we; r.wd = dmem_wdata;
                end else if ({dmem_be, dmem_addr, dmem_we, dmem_wdata} !== {r.be, r.addr, r.we, r.wd}) begin
                    r.unstable = 1'b1;
                end
                if (waited == v.gdly) begin
                    dmem_gnt = 1'b1;
                    gcyc = cyc;
                end
                waited++;
            end else if (gcyc > 0 && !v.wr && cyc == gcyc + 1 + v.rdly) begin
                dmem_rvalid = 1'b1;
                dmem_rdata = v.rdata;
            end
            step();
            cyc++;
        end
        req_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        step();
        r.idle_ok = req_ready && !busy && !resp_valid && !dmem_req;
    endtask

    task automatic check_op(input string tag, input vec_t v, input res_t r);
        chk({tag, " latency"}, 32'(r.resp_cyc), 32'(v.lat));
        chk({tag, " resp_err"}, 32'(r.err), 32'(v.err));
        chk({tag, " resp_rdata"}, r.rdata, v.res);
        chk({tag, " dmem_req issued"}, 32'(r.saw_req), 32'(!v.err));
        chk({tag, " busy/ready during op"}, 32'(r.bad_busy), 32'h0);
        chk({tag, " idle after resp"}, 32'(r.idle_ok), 32'h1);
        if (!v.err) begin
            chk({tag, " dmem_be"}, 32'(r.be), 32'(v.be));
            chk({tag, " dmem_addr"}, r.addr, v.addr & 32'hFFFFFFFC);
            chk({tag, " dmem_we"}, 32'(r.we), 32'(v.wr));
            chk({tag, " req held stable"}, 32'(r.unstable), 32'h0);
            if (v.wr) chk({tag, " dmem_wdata"}, r.wd, v.dwdata);
        end
    endtask

    initial begin
        vec_t tbl[14];
        vec_t v;
        res_t r;
        int   idle_seen, late_resp;
        logic [2:0]  op;
        logic        wr;
        logic [31:0] a;

        rst_n = 1'b0; req_valid = 1'b1; mem_op = MEMOP_W; mem_wr = 1'b1; addr = 32'h100;
        wdata = 32'hFFFFFFFF; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (3) step();
        chk("reset req_ready", 32'(req_ready), 32'h1);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset dmem_req", 32'(dmem_req), 32'h0);
        chk("reset dmem_we", 32'(dmem_we), 32'h0);
        chk("reset dmem_be", 32'(dmem_be), 32'h0);
        chk("reset dmem_addr", dmem_addr, 32'h0);
        chk("reset dmem_wdata", dmem_wdata, 32'h0);
        chk("reset resp_valid", 32'(resp_valid), 32'h0);
        chk("reset resp_err", 32'(resp_err), 32'h0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // op, wr, addr, wdata, rdata, gdly, rdly, be, dmem_wdata, result, err, latency
        tbl[0]  = '{MEMOP_W,  1'b1, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 2};
        tbl[1]  = '{MEMOP_B,  1'b1, 32'h103, 32'h000000A5, 32'h0,        0, 0, 4'h8, 32'hA5A5A5A5, 32'h0,        1'b0, 2};
        tbl[2]  = '{MEMOP_B,  1'b0, 32'h202, 32'h0,        32'h1280FF00, 0, 0, 4'h4, 32'h0,        32'hFFFFFF80, 1'b0, 3};
        tbl[3]  = '{MEMOP_BU, 1'b0, 32'h202, 32'h0,        32'h1280FF00, 0, 0, 4'h4, 32'h0,        32'h00000080, 1'b0, 3};
        tbl[4]  = '{MEMOP_HU, 1'b0, 32'h202, 32'h0,        32'h1280FF00, 0, 0, 4'hC, 32'h0,        32'h00001280, 1'b0, 3};
        tbl[5]  = '{MEMOP_H,  1'b0, 32'h200, 32'h0,        32'h1280FF00, 0, 0, 4'h3, 32'h0,        32'hFFFFFF00, 1'b0, 3};
        tbl[6]  = '{MEMOP_W,  1'b0, 32'h101, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        1'b1, 1};
        tbl[7]  = '{3'b110,   1'b0, 32'h200, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        1'b1, 1};
        tbl[8]  = '{MEMOP_W,  1'b0, 32'h300, 32'h0,        32'h12345678, 3, 2, 4'hF, 32'h0,        32'h12345678, 1'b0, 8};
        tbl[9]  = '{MEMOP_H,  1'b1, 32'h102, 32'h0000BEEF, 32'h0,        0, 0, 4'hC, 32'hBEEFBEEF, 32'h0,        1'b0, 2};
        tbl[10] = '{MEMOP_H,  1'b1, 32'h101, 32'h0000BEEF, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        1'b1, 1};
        tbl[11] = '{MEMOP_B,  1'b0, 32'h001, 32'h0,        32'h00007F00, 0, 0, 4'h2, 32'h0,        32'h0000007F, 1'b0, 3};
        tbl[12] = '{MEMOP_W,  1'b1, 32'h104, 32'h01234567, 32'h0,        2, 0, 4'hF, 32'h01234567, 32'h0,        1'b0, 4};
        tbl[13] = '{MEMOP_H,  1'b0, 32'h206, 32'h0,        32'h80010000, 1, 3, 4'hC, 32'h0,        32'hFFFF8001, 1'b0, 7};
        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i], r);
            check_op($sformatf("vec%0d", i), tbl[i], r);
        end

        // Reset while waiting for read data; the late rvalid must not produce a response.
        req_valid = 1'b1; mem_op = MEMOP_W; mem_wr = 1'b0; addr = 32'h400;
        step();
        req_valid = 1'b0; dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk("midrst busy before reset", 32'(busy), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst idle after reset", 32'({req_ready, busy, dmem_req, resp_valid}), 32'b1000);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        late_resp = 0;
        step();
        dmem_rvalid = 1'b0;
        repeat (3) begin
            if (resp_valid || busy) late_resp++;
            step();
        end
        chk("midrst late rvalid ignored", 32'(late_resp), 32'h0);
        v = model(MEMOP_HU, 1'b0, 32'h402, 32'h0, 32'hABCD0000, 0, 1);
        run_op(v, r);
        check_op("after midrst", v, r);

`ifdef LSU_TIMEOUT_EN
        v = model(MEMOP_W, 1'b0, 32'h500, 32'h0, 32'h0, 100000, 0);
        run_op(v, r);
        chk("timeout latency", 32'(r.resp_cyc), 32'd65);
        chk("timeout resp_err", 32'(r.err), 32'h1);
        chk("timeout resp_rdata", r.rdata, 32'h0);
        chk("timeout idle after", 32'(r.idle_ok), 32'h1);
`else
        req_valid = 1'b1; mem_op = MEMOP_W; mem_wr = 1'b0; addr = 32'h500;
        step();
        req_valid = 1'b0;
        idle_seen = 0;
        repeat (200) begin
            if (!busy || resp_valid) idle_seen++;
            step();
        end
        chk("no-grant still busy", 32'(idle_seen), 32'h0);
        chk("no-grant dmem_req held", 32'(dmem_req), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("no-grant reset recovers", 32'(req_ready), 32'h1);
`endif

        for (int i = 0; i < 250; i++) begin
            op = 3'($urandom);
            wr = 1'($urandom);
            if (wr && op == MEMOP_BU) op = MEMOP_B;
            if (wr && op == MEMOP_HU) op = MEMOP_H;
            a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (op == MEMOP_W) a[1:0] = 2'b00;
                else if (op == MEMOP_H || op == MEMOP_HU) a[0] = 1'b0;
            end
            v = model(op, wr, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            run_op(v, r);
            check_op($sformatf("rnd%0d", i), v, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store unit sitting directly downstream of the control unit in the RV32I datapath.
- Consumes the decoded memory controls (MemOp, MemWr), the ALU-computed address and rs2 store data.
- Drives a word-addressed data-memory port with a request/grant/response handshake.
- Returns the aligned, sign/zero-extended load result for the register write-back mux, plus a stall and error indication.

Parameters:
- TIMEOUT_CYC, 64: cycles waited for dmem_gnt or dmem_rvalid before aborting. Only used when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  core presents a memory instruction.
- req_ready  out  1  unit can accept; high only in IDLE.
- mem_op  in  3  000 B, 001 H, 010 W, 011 BU, 100 HU; 101..111 illegal.
- mem_wr  in  1  1 = store, 0 = load.
- addr  in  32  byte address from the ALU.
- wdata  in  32  rs2 store data.
- resp_valid  out  1  one-cycle pulse, operation finished.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal op, or timeout.
- busy  out  1  high from accept until resp_valid inclusive; used as pipeline stall.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_be  out  4  byte enables.
- dmem_addr  out  32  {addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  memory accepted the request.
- dmem_rvalid  in  1  read data valid; never in the same cycle as its gnt.
- dmem_rdata  in  32  raw read word.

Behaviour:
- Reset (rst_n = 0 at a clk edge): state = IDLE.
  - req_ready = 1.
  - dmem_req, dmem_we, resp_valid, resp_err, busy = 0.
  - dmem_be = 0; dmem_addr, dmem_wdata, resp_rdata = 0.
- Reset mid-operation: the unit abandons the transaction. A dmem_rvalid arriving afterwards is ignored because IDLE ignores rvalid.
- Accept: on req_valid & req_ready, latch mem_op, mem_wr, addr and wdata.
- Error check at accept:
  - Illegal mem_op (101..111) is an error.
  - H/HU with addr[0] = 1 is an error.
  - W with addr[1:0] != 0 is an error.
  - Byte accesses are never misaligned.
  - Any error goes to ERR: no dmem_req is issued, resp_valid + resp_err occur on the next cycle, resp_rdata = 0.
- Stores:
  - B: be = 4'b0001 << addr[1:0]; dmem_wdata = {4{wdata[7:0]}}.
  - H: be = 4'b0011 << {addr[1],1'b0}; dmem_wdata = {2{wdata[15:0]}}.
  - W: be = 4'b1111; dmem_wdata = wdata.
- Loads: be computed the same way, dmem_we = 0.
  - Extract the selected byte/halfword from dmem_rdata using the latched addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- FSM states: IDLE, REQ, WAIT_RSP, RESP, ERR.
  - IDLE: accept → REQ, or ERR on error.
  - REQ: dmem_req = 1 and dmem_addr/be/we/wdata held stable until dmem_gnt. On gnt: store → RESP, load → WAIT_RSP.
  - WAIT_RSP: on dmem_rvalid, register the extended data → RESP.
  - RESP: resp_valid = 1 → IDLE.
  - ERR: resp_valid = 1, resp_err = 1 → IDLE.
- Latency, with accept at cycle N and gnt at first assertion:
  - dmem_req high at N+1.
  - Store: resp_valid at N+2.
  - Load with rvalid at N+2: resp_valid at N+3.
  - Error: resp_valid at N+1.
- Back-to-back: a new request can be accepted on the cycle after resp_valid; there is no overlap.
- req_valid while busy is ignored, because req_ready = 0.
- resp_rdata holds its last value until the next resp_valid.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering REQ or WAIT_RSP and increments each cycle while there.
  - On reaching TIMEOUT_CYC - 1 without gnt/rvalid: dmem_req drops and the FSM goes to ERR (resp_err = 1, resp_rdata = 0).
  - A late rvalid is ignored.
- Not defined: the unit waits indefinitely; no counter logic exists.

Decomposition:
- Shared package lsu_pkg holds:
  - MemOp encodings: MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU.
  - FSM state encoding.
  - Byte-enable widths.
- The same encodings are used by the control unit.
- One combinational sub-module, lsu_load_align: (rdata, addr[1:0], mem_op) → extended 32-bit result. It is reusable by a future cache path.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt at N+1 → dmem_be=1111, dmem_addr=0x100, resp_valid at N+2, resp_err=0.
- SB addr=0x103, wdata=0x000000A5 → dmem_be=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x100.
- LB addr=0x202, dmem_rdata=0x1280FF00 → resp_rdata=0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr=0x202 → 0x00001280.
- LW addr=0x101 → no dmem_req, resp_valid + resp_err at N+1. mem_op=110 gives the same response.
- Load with gnt delayed 3 cycles → addr/be held stable throughout. rst_n=0 while in WAIT_RSP → IDLE next edge; a subsequent rvalid is ignored.
- With LSU_TIMEOUT_EN and TIMEOUT_CYC=64: gnt never asserted → resp_err=1 after 64 cycles in REQ. Without the macro, the unit is still busy after 200 cycles.
